// File: rtl/motion_update_broadcast.sv
// ----------------------------------------------------------------------------
// motion_update_broadcast
//
// Purpose:
//   Walks every cell of a NUM_CELL_X x NUM_CELL_Y x NUM_CELL_Z grid, z fastest,
//   then y, then x. For each cell it reads the particle count from address 0
//   of the source position cache. It then reads each particle's position and
//   displacement from addresses 1..N. The displaced position, folded back into
//   the simulation box, is broadcast with its destination cell id.
//
// Boundary handling (compile-time):
//   MOTION_UPDATE_WRAP_EN defined   : periodic box, an out-of-box sum is
//                                     shifted by one box length L.
//   MOTION_UPDATE_WRAP_EN undefined : clamp, a negative sum becomes 0 and a
//                                     sum >= L becomes L - 1 LSB.
//
// Ports:
//   clk                      clock
//   rst                      asynchronous active-low reset
//   start                    one-cycle pulse, begins a pass (only honoured in idle)
//   out_src_cell             {x,y,z} of the cell being read (steers external mux)
//   out_read_address         read address shared by position and displacement memories
//   out_rden                 read enable for both memories
//   in_position              read data, one cycle after the address: count or position
//   in_displacement          read data, one cycle after the address: signed displacement
//   out_motion_update_enable high for the whole broadcast window
//   out_data                 updated position {posz,posy,posx}, zero when not valid
//   out_data_dst_cell        destination cell {x,y,z}, zero when not valid
//   out_data_valid           broadcast strobe, 2 cycles after the particle's address
//   out_done                 one-cycle pulse at the end of a pass
// ----------------------------------------------------------------------------
module motion_update_broadcast #(
    parameter int unsigned DATA_WIDTH    = 96,
    parameter int unsigned COORD_WIDTH   = 32,
    parameter int unsigned FRAC_WIDTH    = 24,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned CELL_ID_WIDTH = 4,
    parameter int unsigned NUM_CELL_X    = 3,
    parameter int unsigned NUM_CELL_Y    = 3,
    parameter int unsigned NUM_CELL_Z    = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [3*CELL_ID_WIDTH-1:0] out_src_cell,
    output logic [ADDR_WIDTH-1:0]      out_read_address,
    output logic                       out_rden,
    input  logic [DATA_WIDTH-1:0]      in_position,
    input  logic [DATA_WIDTH-1:0]      in_displacement,
    output logic                       out_motion_update_enable,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
    output logic                       out_data_valid,
    output logic                       out_done
);

    typedef enum logic [2:0] {
        StIdle,
        StRdNum,
        StWaitNum,
        StRdPart,
        StDrain,
        StNextCell,
        StFinish
    } state_e;

    localparam logic [CELL_ID_WIDTH-1:0] CellOne = CELL_ID_WIDTH'(1);
    localparam logic [CELL_ID_WIDTH-1:0] LastX   = CELL_ID_WIDTH'(NUM_CELL_X);
    localparam logic [CELL_ID_WIDTH-1:0] LastY   = CELL_ID_WIDTH'(NUM_CELL_Y);
    localparam logic [CELL_ID_WIDTH-1:0] LastZ   = CELL_ID_WIDTH'(NUM_CELL_Z);

    // Box length per axis in fixed point (one cell edge = 1 << FRAC_WIDTH).
    localparam logic [COORD_WIDTH-1:0] LenX = COORD_WIDTH'(NUM_CELL_X) << FRAC_WIDTH;
    localparam logic [COORD_WIDTH-1:0] LenY = COORD_WIDTH'(NUM_CELL_Y) << FRAC_WIDTH;
    localparam logic [COORD_WIDTH-1:0] LenZ = COORD_WIDTH'(NUM_CELL_Z) << FRAC_WIDTH;

    localparam int unsigned IntWidth = COORD_WIDTH - FRAC_WIDTH;

    // ------------------------------------------------------------------------
    // Per-axis arithmetic
    // ------------------------------------------------------------------------

    // pos + disp modulo 2^COORD_WIDTH, then folded into [0, len). The
    // displacement is smaller than one cell edge, so a set MSB can only mean
    // the sum went below zero.
    function automatic logic [COORD_WIDTH-1:0] fold_axis(
        input logic [COORD_WIDTH-1:0] pos,
        input logic [COORD_WIDTH-1:0] disp,
        input logic [COORD_WIDTH-1:0] len
    );
        logic [COORD_WIDTH-1:0] sum;
        logic [COORD_WIDTH-1:0] res;
        sum = pos + disp;
`ifdef MOTION_UPDATE_WRAP_EN
        if (sum[COORD_WIDTH-1]) begin
            res = sum + len;
        end else if (sum >= len) begin
            res = sum - len;
        end else begin
            res = sum;
        end
`else
        if (sum[COORD_WIDTH-1]) begin
            res = '0;
        end else if (sum >= len) begin
            res = len - COORD_WIDTH'(1);
        end else begin
            res = sum;
        end
`endif
        return res;
    endfunction

    // Cell ids are 1-based, so the integer part plus one.
    function automatic logic [CELL_ID_WIDTH-1:0] cell_of(input logic [COORD_WIDTH-1:0] p);
        logic [IntWidth-1:0] whole;
        whole = p[COORD_WIDTH-1:FRAC_WIDTH];
        return CELL_ID_WIDTH'(whole + IntWidth'(1));
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e                   state_q, state_d;
    logic [CELL_ID_WIDTH-1:0] cell_x_q, cell_x_d;
    logic [CELL_ID_WIDTH-1:0] cell_y_q, cell_y_d;
    logic [CELL_ID_WIDTH-1:0] cell_z_q, cell_z_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]    num_q, num_d;
    // Marks that the read data arriving this cycle belongs to a particle.
    logic                     rd_valid_q, rd_valid_d;

    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [3*CELL_ID_WIDTH-1:0] dst_q, dst_d;
    logic                       valid_q;

    logic last_cell;
    assign last_cell = (cell_x_q == LastX) && (cell_y_q == LastY) && (cell_z_q == LastZ);

    // ------------------------------------------------------------------------
    // Compute stage: read data -> registered broadcast
    // ------------------------------------------------------------------------
    logic [COORD_WIDTH-1:0] new_x, new_y, new_z;

    assign new_x = fold_axis(in_position[COORD_WIDTH-1:0],
                             in_displacement[COORD_WIDTH-1:0], LenX);
    assign new_y = fold_axis(in_position[2*COORD_WIDTH-1:COORD_WIDTH],
                             in_displacement[2*COORD_WIDTH-1:COORD_WIDTH], LenY);
    assign new_z = fold_axis(in_position[3*COORD_WIDTH-1:2*COORD_WIDTH],
                             in_displacement[3*COORD_WIDTH-1:2*COORD_WIDTH], LenZ);

    always_comb begin
        data_d = '0;
        dst_d  = '0;
        if (rd_valid_q) begin
            data_d = DATA_WIDTH'({new_z, new_y, new_x});
            dst_d  = {cell_of(new_x), cell_of(new_y), cell_of(new_z)};
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cell_x_d   = cell_x_q;
        cell_y_d   = cell_y_q;
        cell_z_d   = cell_z_q;
        addr_d     = addr_q;
        num_d      = num_q;
        rd_valid_d = 1'b0;

        out_rden                 = 1'b0;
        out_read_address         = '0;
        out_motion_update_enable = 1'b0;
        out_done                 = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRdNum;
                    cell_x_d = CellOne;
                    cell_y_d = CellOne;
                    cell_z_d = CellOne;
                end
            end

            StRdNum: begin
                out_motion_update_enable = 1'b1;
                out_rden                 = 1'b1;
                state_d                  = StWaitNum;
            end

            StWaitNum: begin
                // Address 0 of the cache holds the particle count.
                out_motion_update_enable = 1'b1;
                num_d                    = in_position[ADDR_WIDTH-1:0];
                addr_d                   = ADDR_WIDTH'(1);
                if (in_position[ADDR_WIDTH-1:0] == '0) begin
                    state_d = StNextCell;
                end else begin
                    state_d = StRdPart;
                end
            end

            StRdPart: begin
                out_motion_update_enable = 1'b1;
                out_rden                 = 1'b1;
                out_read_address         = addr_q;
                rd_valid_d               = 1'b1;
                if (addr_q == num_q) begin
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end

            StDrain: begin
                // The last particle's data is in the compute stage while
                // rd_valid_q is set; leave once it has reached the output.
                out_motion_update_enable = 1'b1;
                if (!rd_valid_q) begin
                    state_d = StNextCell;
                end
            end

            StNextCell: begin
                out_motion_update_enable = 1'b1;
                if (last_cell) begin
                    cell_x_d = '0;
                    cell_y_d = '0;
                    cell_z_d = '0;
                    state_d  = StFinish;
                end else begin
                    state_d = StRdNum;
                    if (cell_z_q != LastZ) begin
                        cell_z_d = cell_z_q + CellOne;
                    end else begin
                        cell_z_d = CellOne;
                        if (cell_y_q != LastY) begin
                            cell_y_d = cell_y_q + CellOne;
                        end else begin
                            cell_y_d = CellOne;
                            cell_x_d = cell_x_q + CellOne;
                        end
                    end
                end
            end

            StFinish: begin
                // Enable is already low here, so done follows the window.
                out_done = 1'b1;
                state_d  = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign out_src_cell      = {cell_x_q, cell_y_q, cell_z_q};
    assign out_data          = data_q;
    assign out_data_dst_cell = dst_q;
    assign out_data_valid    = valid_q;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cell_x_q   <= '0;
            cell_y_q   <= '0;
            cell_z_q   <= '0;
            addr_q     <= '0;
            num_q      <= '0;
            rd_valid_q <= 1'b0;
            data_q     <= '0;
            dst_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cell_x_q   <= cell_x_d;
            cell_y_q   <= cell_y_d;
            cell_z_q   <= cell_z_d;
            addr_q     <= addr_d;
            num_q      <= num_d;
            rd_valid_q <= rd_valid_d;
            data_q     <= data_d;
            dst_q      <= dst_d;
            valid_q    <= rd_valid_q;
        end
    end

endmodule

// File: tb/tb_motion_update_broadcast.sv
// ----------------------------------------------------------------------------
// tb_motion_update_broadcast
//
// Bench for motion_update_broadcast at default parameters (3x3x3 grid,
// 32-bit coordinates, 24 fraction bits). It emulates the position cache and
// the displacement memory. It predicts the broadcast stream from the grid
// contents using plain integer arithmetic, and compares every cycle.
// Honours MOTION_UPDATE_WRAP_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_motion_update_broadcast;

    localparam int CW   = 32;
    localparam int FW   = 24;
    localparam int CIW  = 4;
    localparam int DW   = 96;
    localparam int NC   = 27;
    localparam int MAXP = 16;
    localparam longint LEN = 3 * (longint'(1) << FW);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [11:0]   dst;
    } bc_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [11:0]   out_src_cell;
    logic [7:0]    out_read_address;
    logic          out_rden;
    logic [DW-1:0] in_position = '0;
    logic [DW-1:0] in_displacement = '0;
    logic          out_motion_update_enable;
    logic [DW-1:0] out_data;
    logic [11:0]   out_data_dst_cell;
    logic          out_data_valid;
    logic          out_done;

    motion_update_broadcast dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .out_src_cell             (out_src_cell),
        .out_read_address         (out_read_address),
        .out_rden                 (out_rden),
        .in_position              (in_position),
        .in_displacement          (in_displacement),
        .out_motion_update_enable (out_motion_update_enable),
        .out_data                 (out_data),
        .out_data_dst_cell        (out_data_dst_cell),
        .out_data_valid           (out_data_valid),
        .out_done                 (out_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ------------------------------------------------------------------------
    // Grid contents and memory emulation
    // ------------------------------------------------------------------------
    int            cnt[NC];
    logic [DW-1:0] pos_mem[NC][MAXP];
    logic [DW-1:0] disp_mem[NC][MAXP];
    int            ridx;

    function automatic int cell_idx(input logic [11:0] c);
        int x, y, z;
        x = int'(c[11:8]);
        y = int'(c[7:4]);
        z = int'(c[3:0]);
        if (x < 1 || x > 3 || y < 1 || y > 3 || z < 1 || z > 3) return -1;
        return (x - 1) * 9 + (y - 1) * 3 + (z - 1);
    endfunction

    always @(posedge clk) begin
        if (out_rden) begin
            ridx = cell_idx(out_src_cell);
            if (ridx < 0 || int'(out_read_address) >= MAXP) begin
                in_position     <= '0;
                in_displacement <= '0;
            end else if (out_read_address == 8'd0) begin
                in_position     <= DW'(cnt[ridx]);
                in_displacement <= '0;
            end else begin
                in_position     <= pos_mem[ridx][out_read_address];
                in_displacement <= disp_mem[ridx][out_read_address];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic longint fold_ax(input longint p, input longint d);
        longint s;
        s = p + d;
`ifdef MOTION_UPDATE_WRAP_EN
        if (s < 0) s = s + LEN;
        else if (s >= LEN) s = s - LEN;
`else
        if (s < 0) s = 0;
        else if (s >= LEN) s = LEN - 1;
`endif
        return s;
    endfunction

    function automatic bc_t model(input logic [DW-1:0] pos, input logic [DW-1:0] disp);
        bc_t    r;
        longint p, d, s, id;
        r = '0;
        for (int a = 0; a < 3; a++) begin
            p  = longint'(pos[a*CW +: CW]);
            d  = longint'($signed(disp[a*CW +: CW]));
            s  = fold_ax(p, d);
            id = (s >> FW) + 1;
            r.data[a*CW +: CW]        = CW'(s);
            r.dst[(2-a)*CIW +: CIW]   = CIW'(id);
        end
        return r;
    endfunction

    bc_t         exp_q[$];
    bc_t         cap_q[$];
    int          issue_q[$];
    logic [11:0] order[NC];
    int          exp_total;

    task automatic build_expected();
        int k;
        exp_q.delete();
        exp_total = 0;
        k = 0;
        for (int x = 1; x <= 3; x++)
            for (int y = 1; y <= 3; y++)
                for (int z = 1; z <= 3; z++) begin
                    order[k] = {CIW'(x), CIW'(y), CIW'(z)};
                    for (int p = 1; p <= cnt[k]; p++) begin
                        exp_q.push_back(model(pos_mem[k][p], disp_mem[k][p]));
                        exp_total++;
                    end
                    k++;
                end
    endtask

    // ------------------------------------------------------------------------
    // Per-cycle monitor
    // ------------------------------------------------------------------------
    int  cyc = 0;
    int  rdnum_cnt, valid_cnt, done_cnt, cell_i;
    bit  prev_en = 1'b0;
    bit  mon_on = 1'b0;
    bc_t mon_e;
    int  mon_iss;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst && mon_on) begin
            if (out_rden) begin
                if (out_read_address == 8'd0) begin
                    rdnum_cnt++;
                    chk("en_at_rdnum", out_motion_update_enable, 1);
                    chk("cell_in_range", cell_i < NC, 1);
                    if (cell_i < NC) chk("cell_order", out_src_cell, order[cell_i]);
                    cell_i++;
                end else begin
                    issue_q.push_back(cyc);
                end
            end
            if (out_data_valid) begin
                valid_cnt++;
                cap_q.push_back({out_data, out_data_dst_cell});
                chk("en_during_valid", out_motion_update_enable, 1);
                chk("valid_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("bcast_data", out_data, mon_e.data);
                    chk("bcast_dst", out_data_dst_cell, mon_e.dst);
                end
                chk("issue_pending", issue_q.size() > 0, 1);
                if (issue_q.size() > 0) begin
                    mon_iss = issue_q.pop_front();
                    chk("valid_latency", cyc - mon_iss, 2);
                end
            end else begin
                chk("idle_outputs_zero", {out_data, out_data_dst_cell}, '0);
            end
            if (out_done) begin
                done_cnt++;
                chk("en_low_at_done", out_motion_update_enable, 0);
                chk("en_high_before_done", prev_en, 1);
            end
            prev_en = out_motion_update_enable;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    function automatic logic [31:0] rand_pos();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(0, 32'h000F_FFFF);
            1:       return 32'h02FF_FFFF - $urandom_range(0, 32'h000F_FFFF);
            default: return $urandom_range(0, 32'h02FF_FFFF);
        endcase
    endfunction

    function automatic logic [31:0] rand_disp();
        logic [31:0] m;
        m = $urandom_range(0, 32'h00FF_FFFF);
        return ($urandom_range(0, 1) != 0) ? m : -m;
    endfunction

    task automatic clear_mem();
        for (int k = 0; k < NC; k++) cnt[k] = 0;
    endtask

    task automatic fill_random(input int maxn);
        for (int k = 0; k < NC; k++) begin
            cnt[k] = $urandom_range(0, maxn);
            for (int p = 1; p <= cnt[k]; p++) begin
                pos_mem[k][p]  = {rand_pos(), rand_pos(), rand_pos()};
                disp_mem[k][p] = {rand_disp(), rand_disp(), rand_disp()};
            end
        end
    endtask

    task automatic arm_pass();
        build_expected();
        issue_q.delete();
        cap_q.delete();
        cell_i    = 0;
        rdnum_cnt = 0;
        valid_cnt = 0;
        done_cnt  = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_pass(input bit extra_start);
        int t;
        arm_pass();
        t = 0;
        while (done_cnt == 0 && t < 20000) begin
            @(negedge clk);
            #1;
            t++;
            start = (extra_start && t == 12);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("single_done", done_cnt, 1);
        chk("rdnum_reads", rdnum_cnt, 27);
        chk("valid_count", valid_cnt, exp_total);
        chk("all_broadcast", exp_q.size(), 0);
        chk("no_pending_issue", issue_q.size(), 0);
        chk("en_low_after_pass", out_motion_update_enable, 0);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    bc_t m;
    int  t0;

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {out_src_cell, out_read_address, out_rden,
                           out_motion_update_enable, out_data_valid, out_done}, '0);
        chk("reset_data", {out_data, out_data_dst_cell}, '0);
        rst = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);

        // Model pinned against hand-computed values.
        m = model({32'h0040_0000, 32'h0040_0000, 32'h0080_0000},
                  {32'h0, 32'h0, 32'h0090_0000});
        chk("model_sum_x", m.data[31:0], 32'h0110_0000);
        chk("model_dst", m.dst, 12'h211);
        m = model({32'h0, 32'h0, 32'h0010_0000}, {32'h0, 32'h0, 32'hFFE0_0000});
`ifdef MOTION_UPDATE_WRAP_EN
        chk("model_wrap_neg", m.data[31:0], 32'h02F0_0000);
        chk("model_wrap_neg_dst", m.dst[11:8], 4'd3);
`else
        chk("model_clamp_neg", m.data[31:0], 32'h0);
        chk("model_clamp_neg_dst", m.dst[11:8], 4'd1);
`endif

        // Single cell, two particles, no motion.
        clear_mem();
        cnt[0] = 2;
        for (int p = 1; p <= 2; p++) begin
            pos_mem[0][p]  = {8'h0, 24'($urandom), 8'h0, 24'($urandom), 8'h0, 24'($urandom)};
            disp_mem[0][p] = '0;
        end
        run_pass(1'b0);
        chk("a_count", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            chk("a_pos1", cap_q[0].data, pos_mem[0][1]);
            chk("a_pos2", cap_q[1].data, pos_mem[0][2]);
            chk("a_dst1", cap_q[0].dst, 12'h111);
            chk("a_dst2", cap_q[1].dst, 12'h111);
        end

        // Boundary crossings along x.
        clear_mem();
        cnt[0] = 3;
        pos_mem[0][1]  = {32'h0040_0000, 32'h0040_0000, 32'h0080_0000};
        disp_mem[0][1] = {32'h0, 32'h0, 32'h0090_0000};
        pos_mem[0][2]  = {32'h0040_0000, 32'h0040_0000, 32'h0010_0000};
        disp_mem[0][2] = {32'h0, 32'h0, 32'hFFE0_0000};
        pos_mem[0][3]  = {32'h0040_0000, 32'h0040_0000, 32'h02F0_0000};
        disp_mem[0][3] = {32'h0, 32'h0, 32'h0020_0000};
        run_pass(1'b0);
        chk("b_count", cap_q.size(), 3);
        if (cap_q.size() == 3) begin
            chk("b_cross_x", cap_q[0].data[31:0], 32'h0110_0000);
            chk("b_cross_dst", cap_q[0].dst, 12'h211);
            chk("b_y_kept", cap_q[0].data[63:32], 32'h0040_0000);
`ifdef MOTION_UPDATE_WRAP_EN
            chk("b_wrap_low_x", cap_q[1].data[31:0], 32'h02F0_0000);
            chk("b_wrap_low_dst", cap_q[1].dst[11:8], 4'd3);
            chk("b_wrap_high_x", cap_q[2].data[31:0], 32'h0010_0000);
            chk("b_wrap_high_dst", cap_q[2].dst[11:8], 4'd1);
`else
            chk("b_clamp_low_x", cap_q[1].data[31:0], 32'h0);
            chk("b_clamp_low_dst", cap_q[1].dst[11:8], 4'd1);
            chk("b_clamp_high_x", cap_q[2].data[31:0], 32'h02FF_FFFF);
            chk("b_clamp_high_dst", cap_q[2].dst[11:8], 4'd3);
`endif
        end

        // Empty grid.
        clear_mem();
        run_pass(1'b0);
        chk("c_no_valid", valid_cnt, 0);

        // Random grids; the second one sees a stray start mid-pass.
        for (int i = 0; i < 4; i++) begin
            fill_random(6);
            run_pass(i == 1);
        end

        // Reset while the 2nd of 5 particles is on the output.
        fill_random(3);
        cnt[0] = 5;
        for (int p = 1; p <= 5; p++) begin
            pos_mem[0][p]  = {rand_pos(), rand_pos(), rand_pos()};
            disp_mem[0][p] = {rand_disp(), rand_disp(), rand_disp()};
        end
        arm_pass();
        t0 = 0;
        while (valid_cnt < 2 && t0 < 200) begin
            @(negedge clk);
            #1;
            t0++;
        end
        chk("r_reached_2nd", valid_cnt, 2);
        rst = 1'b0;
        #1;
        chk("r_ctrl_zero", {out_src_cell, out_read_address, out_rden,
                            out_motion_update_enable, out_data_valid, out_done}, '0);
        chk("r_data_zero", {out_data, out_data_dst_cell}, '0);
        exp_q.delete();
        issue_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("r_hold_done", out_done, 0);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("r_stays_idle", {out_motion_update_enable, out_rden, out_data_valid}, 3'b000);
        chk("r_no_done", done_cnt, 0);
        run_pass(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
